multicycle_main_control: RTL and testbench

Moore-style main control FSM for the multicycle MIPS core. It decodes the instruction opcode and sequences fetch/decode/execute/memory/writeback. It is the producer of the 3-bit ALUOp consumed by the ALU control decoder, and drives every datapath mux/enable. A memory-ready handshake stalls it on memory access.

---
 rtl/multicycle_main_control.sv | 234 +++++++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/mem/wb.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes; otherwise they act as NOPs.
module multicycle_main_control #(
  parameter int OP_WIDTH    = 6,
  parameter int ALUOP_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OP_WIDTH-1:0]    OpCode,
  input  logic                   MemReady,
  output logic                   PCWrite,
  output logic                   PCWriteCond,
  output logic                   BranchNE,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic [1:0]             RegDst,
  output logic [1:0]             MemtoReg,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic                   ZeroExt,
  output logic [ALUOP_WIDTH-1:0] ALUOp,
  output logic [1:0]             PCSource,
  output logic                   Exception,
  output logic [3:0]             State
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    I_EXEC    = 4'd10,
    I_WB      = 4'd11,
    JUMP      = 4'd12,
    JAL       = 4'd13,
    TRAP      = 4'd14
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_R    = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(6'b101011);
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] OP_BNE  = OP_WIDTH'(6'b000101);
  localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(6'b001000);
  localparam logic [OP_WIDTH-1:0] OP_ORI  = OP_WIDTH'(6'b001101);
  localparam logic [OP_WIDTH-1:0] OP_ANDI = OP_WIDTH'(6'b001100);
  localparam logic [OP_WIDTH-1:0] OP_LUI  = OP_WIDTH'(6'b001111);
  localparam logic [OP_WIDTH-1:0] OP_J    = OP_WIDTH'(6'b000010);
  localparam logic [OP_WIDTH-1:0] OP_JAL  = OP_WIDTH'(6'b000011);

  localparam logic [ALUOP_WIDTH-1:0] AO_ADD  = ALUOP_WIDTH'(3'b000);
  localparam logic [ALUOP_WIDTH-1:0] AO_SUB  = ALUOP_WIDTH'(3'b001);
  localparam logic [ALUOP_WIDTH-1:0] AO_AND  = ALUOP_WIDTH'(3'b010);
  localparam logic [ALUOP_WIDTH-1:0] AO_ADDI = ALUOP_WIDTH'(3'b100);
  localparam logic [ALUOP_WIDTH-1:0] AO_OR   = ALUOP_WIDTH'(3'b101);
  localparam logic [ALUOP_WIDTH-1:0] AO_LUI  = ALUOP_WIDTH'(3'b110);
  localparam logic [ALUOP_WIDTH-1:0] AO_RTYP = ALUOP_WIDTH'(3'b111);

  state_t                state;
  state_t                state_nx;
  logic [OP_WIDTH-1:0]   op_q;

  logic is_r;
  logic is_mem;
  logic is_br;
  logic is_imm;
  logic is_j;
  logic is_jal;

  assign is_r   = (OpCode == OP_R);
  assign is_mem = (OpCode == OP_LW) || (OpCode == OP_SW);
  assign is_br  = (OpCode == OP_BEQ) || (OpCode == OP_BNE);
  assign is_imm = (OpCode == OP_ADDI) || (OpCode == OP_ORI) ||
                  (OpCode == OP_ANDI) || (OpCode == OP_LUI);
  assign is_j   = (OpCode == OP_J);
  assign is_jal = (OpCode == OP_JAL);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      state_nx = FETCH;
      FETCH:     if (MemReady) state_nx = DECODE;
      DECODE: begin
        unique case (1'b1)
          is_r:    state_nx = R_EXEC;
          is_mem:  state_nx = MEM_ADDR;
          is_br:   state_nx = BRANCH;
          is_imm:  state_nx = I_EXEC;
          is_j:    state_nx = JUMP;
          is_jal:  state_nx = JAL;
`ifdef ILLEGAL_TRAP_EN
          default: state_nx = TRAP;
`else
          default: state_nx = FETCH;
`endif
        endcase
      end
      MEM_ADDR:  state_nx = (op_q == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (MemReady) state_nx = MEM_WB;
      MEM_WB:    state_nx = FETCH;
      MEM_WRITE: if (MemReady) state_nx = FETCH;
      R_EXEC:    state_nx = R_WB;
      R_WB:      state_nx = FETCH;
      BRANCH:    state_nx = FETCH;
      I_EXEC:    state_nx = I_WB;
      I_WB:      state_nx = FETCH;
      JUMP:      state_nx = FETCH;
      JAL:       state_nx = FETCH;
`ifdef ILLEGAL_TRAP_EN
      TRAP:      state_nx = TRAP;
`else
      TRAP:      state_nx = FETCH;
`endif
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == DECODE) op_q <= OpCode;
    end
  end

  // Moore decode; only FETCH's IR/PC load looks at MemReady.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNE    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 2'd0;
    MemtoReg    = 2'd0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    ZeroExt     = 1'b0;
    ALUOp       = AO_ADD;
    PCSource    = 2'd0;
    Exception   = 1'b0;
    unique case (state)
      IDLE: ;
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      DECODE: ALUSrcB = 2'd3;
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'd1;
      end
      MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = AO_RTYP;
      end
      R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 2'd1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = AO_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'd1;
        BranchNE    = (op_q == OP_BNE);
      end
      I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        unique case (op_q)
          OP_ORI: begin
            ALUOp   = AO_OR;
            ZeroExt = 1'b1;
          end
          OP_ANDI: begin
            ALUOp   = AO_AND;
            ZeroExt = 1'b1;
          end
          OP_LUI:  ALUOp = AO_LUI;
          default: ALUOp = AO_ADDI;
        endcase
      end
      I_WB: RegWrite = 1'b1;
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
      end
      JAL: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
        RegWrite = 1'b1;
        RegDst   = 2'd2;
        MemtoReg = 2'd2;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: Exception = 1'b1;
`else
      TRAP: ;
`endif
      default: ;
    endcase
  end

  assign State = state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control.
// Walks each instruction class state-by-state with hand-computed outputs.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OpCode;
  logic       MemReady;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       BranchNE;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ZeroExt;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       Exception;
  logic [3:0] State;
  logic [21:0] ctl;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_main_control dut (
    .clk(clk), .reset(reset), .OpCode(OpCode),
    .MemReady(MemReady), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ZeroExt(ZeroExt), .ALUOp(ALUOp), .PCSource(PCSource),
    .Exception(Exception), .State(State)
  );

  assign ctl = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead,
                MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                ALUSrcA, ALUSrcB, ZeroExt, ALUOp, PCSource,
                Exception};

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] s);
    @(negedge clk);
    check(tag, 32'(State), 32'(s));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    OpCode   = 6'b000000;
    MemReady = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_state", 32'(State), 0);
    check("rst_ctl", 32'(ctl), 0);
    reset = 1'b1;
    #1;
    check("idle_state", 32'(State), 0);
    check("idle_ctl", 32'(ctl), 0);

    step("fetch", 4'd1);
    check("fetch_memrd", 32'(MemRead), 1);
    check("fetch_irw", 32'(IRWrite), 1);
    check("fetch_pcw", 32'(PCWrite), 1);
    check("fetch_srcb", 32'(ALUSrcB), 1);
    check("fetch_iord", 32'(IorD), 0);
    MemReady = 1'b0;
    #1;
    check("fstall_irw", 32'(IRWrite), 0);
    check("fstall_pcw", 32'(PCWrite), 0);
    step("fetch_hold", 4'd1);
    MemReady = 1'b1;

    // R-type
    OpCode = 6'b000000;
    step("r_dec", 4'd2);
    check("dec_srcb", 32'(ALUSrcB), 3);
    check("dec_srca", 32'(ALUSrcA), 0);
    step("r_exec", 4'd7);
    check("r_aluop", 32'(ALUOp), 7);
    check("r_srca", 32'(ALUSrcA), 1);
    check("r_srcb", 32'(ALUSrcB), 0);
    step("r_wb", 4'd8);
    check("rwb_regw", 32'(RegWrite), 1);
    check("rwb_dst", 32'(RegDst), 1);
    check("rwb_m2r", 32'(MemtoReg), 0);
    step("r_done", 4'd1);

    // LW with 3 wait cycles in MEM_READ
    OpCode = 6'b100011;
    step("lw_dec", 4'd2);
    step("lw_addr", 4'd3);
    check("lw_srcb", 32'(ALUSrcB), 2);
    check("lw_srca", 32'(ALUSrcA), 1);
    step("lw_rd1", 4'd4);
    check("lw_memrd", 32'(MemRead), 1);
    check("lw_iord", 32'(IorD), 1);
    MemReady = 1'b0;
    step("lw_rd2", 4'd4);
    step("lw_rd3", 4'd4);
    step("lw_rd4", 4'd4);
    MemReady = 1'b1;
    step("lw_wb", 4'd5);
    check("lw_m2r", 32'(MemtoReg), 1);
    check("lw_regw", 32'(RegWrite), 1);
    check("lw_dst", 32'(RegDst), 0);
    step("lw_done", 4'd1);

    // SW
    OpCode = 6'b101011;
    step("sw_dec", 4'd2);
    step("sw_addr", 4'd3);
    step("sw_wr", 4'd6);
    check("sw_memwr", 32'(MemWrite), 1);
    check("sw_iord", 32'(IorD), 1);
    check("sw_memrd", 32'(MemRead), 0);
    step("sw_done", 4'd1);

    // BNE; opcode input changes after decode
    OpCode = 6'b000101;
    step("bne_dec", 4'd2);
    step("bne_br", 4'd9);
    OpCode = 6'b000000;
    #1;
    check("bne_aluop", 32'(ALUOp), 1);
    check("bne_pcwc", 32'(PCWriteCond), 1);
    check("bne_ne", 32'(BranchNE), 1);
    check("bne_pcsrc", 32'(PCSource), 1);
    step("bne_done", 4'd1);

    OpCode = 6'b000100;
    step("beq_dec", 4'd2);
    step("beq_br", 4'd9);
    check("beq_ne", 32'(BranchNE), 0);
    check("beq_pcwc", 32'(PCWriteCond), 1);
    step("beq_done", 4'd1);

    // Immediates
    OpCode = 6'b001101;
    step("ori_dec", 4'd2);
    step("ori_ex", 4'd10);
    check("ori_aluop", 32'(ALUOp), 5);
    check("ori_zext", 32'(ZeroExt), 1);
    check("ori_srcb", 32'(ALUSrcB), 2);
    step("ori_wb", 4'd11);
    check("iwb_regw", 32'(RegWrite), 1);
    check("iwb_dst", 32'(RegDst), 0);
    check("iwb_m2r", 32'(MemtoReg), 0);
    step("ori_done", 4'd1);

    OpCode = 6'b001111;
    step("lui_dec", 4'd2);
    step("lui_ex", 4'd10);
    check("lui_aluop", 32'(ALUOp), 6);
    check("lui_zext", 32'(ZeroExt), 0);
    step("lui_wb", 4'd11);
    step("lui_done", 4'd1);

    OpCode = 6'b001100;
    step("andi_dec", 4'd2);
    step("andi_ex", 4'd10);
    check("andi_aluop", 32'(ALUOp), 2);
    check("andi_zext", 32'(ZeroExt), 1);
    step("andi_wb", 4'd11);
    step("andi_done", 4'd1);

    OpCode = 6'b001000;
    step("addi_dec", 4'd2);
    step("addi_ex", 4'd10);
    check("addi_aluop", 32'(ALUOp), 4);
    check("addi_zext", 32'(ZeroExt), 0);
    step("addi_wb", 4'd11);
    step("addi_done", 4'd1);

    // Jumps
    OpCode = 6'b000010;
    step("j_dec", 4'd2);
    step("j_st", 4'd12);
    check("j_pcw", 32'(PCWrite), 1);
    check("j_pcsrc", 32'(PCSource), 2);
    check("j_regw", 32'(RegWrite), 0);
    step("j_done", 4'd1);

    OpCode = 6'b000011;
    step("jal_dec", 4'd2);
    step("jal_st", 4'd13);
    check("jal_dst", 32'(RegDst), 2);
    check("jal_m2r", 32'(MemtoReg), 2);
    check("jal_pcsrc", 32'(PCSource), 2);
    check("jal_pcw", 32'(PCWrite), 1);
    check("jal_regw", 32'(RegWrite), 1);
    step("jal_done", 4'd1);

    // Illegal opcode
    OpCode = 6'b111111;
    step("ill_dec", 4'd2);
`ifdef ILLEGAL_TRAP_EN
    step("trap1", 4'd14);
    check("trap_ctl", 32'(ctl), 1);
    step("trap2", 4'd14);
    step("trap3", 4'd14);
    check("trap_exc", 32'(Exception), 1);
    reset = 1'b0;
    #1;
    check("trap_rst", 32'(State), 0);
    @(negedge clk);
    reset = 1'b1;
    step("trap_fetch", 4'd1);
`else
    step("ill_nop", 4'd1);
    check("ill_exc", 32'(Exception), 0);
`endif

    // Reset during a MEM_WRITE wait
    OpCode = 6'b101011;
    step("swr_dec", 4'd2);
    step("swr_addr", 4'd3);
    step("swr_wr1", 4'd6);
    MemReady = 1'b0;
    step("swr_wr2", 4'd6);
    check("swr_memwr", 32'(MemWrite), 1);
    reset = 1'b0;
    #1;
    check("swr_rst_memwr", 32'(MemWrite), 0);
    check("swr_rst_state", 32'(State), 0);
    check("swr_rst_ctl", 32'(ctl), 0);
    step("swr_rst_hold", 4'd0);
    check("swr_hold_memwr", 32'(MemWrite), 0);
    reset    = 1'b1;
    MemReady = 1'b1;
    step("swr_fetch", 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
